// File: rtl/sbox_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency S-box datapath among N_REQ byte lanes.
// Tracks byte ownership through the datapath and returns results via per-lane credit-limited FIFOs.
module sbox_rr_sched #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned LAT       = 3,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           sbox_in,
    output logic                 sbox_in_valid,
    input  logic [7:0]           sbox_out,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [8*N_REQ-1:0]   rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [IW-1:0] rr_q, rr_d;
    logic [7:0]    in_q;
    logic [LAT:0]  tag_vld_q;
    logic [IW-1:0] tag_own_q [LAT+1];

    logic [7:0]    mem_q      [N_REQ][RSP_DEPTH];
    logic [PW-1:0] rd_ptr_q   [N_REQ];
    logic [PW-1:0] wr_ptr_q   [N_REQ];
    logic [CW-1:0] fifo_cnt_q [N_REQ];
    logic [CW-1:0] infl_cnt_q [N_REQ];

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic             gnt_any;
    logic [IW-1:0]    gnt_idx;
    logic [7:0]       gnt_byte;
    logic [CW:0]      used [N_REQ];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts both queued results and bytes still inside the datapath.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            used[i] = (CW+1)'(fifo_cnt_q[i]) + (CW+1)'(infl_cnt_q[i]);
            elig[i] = req_valid[i] && (used[i] < (CW+1)'(RSP_DEPTH));
        end
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_any && elig[IW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        // No handshake may complete while the block is being cleared.
        if (rst) gnt_any = 1'b0;
    end

    always_comb begin
        gnt      = '0;
        gnt_byte = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_any && (gnt_idx == IW'(k))) begin
                gnt[k]   = 1'b1;
                gnt_byte = req_data[8*k +: 8];
            end
        end
        if (!gnt_any)                        rr_d = rr_q;
        else if (gnt_idx == IW'(N_REQ - 1))  rr_d = '0;
        else                                 rr_d = gnt_idx + IW'(1);
    end

    assign req_ready     = gnt;
    assign sbox_in       = in_q;
    assign sbox_in_valid = tag_vld_q[0];

    // Stage 0 of the tag pipe is the issue register; stage LAT lines up with sbox_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            in_q      <= '0;
            tag_vld_q <= '0;
            for (int unsigned j = 0; j <= LAT; j++) tag_own_q[j] <= '0;
        end else begin
            rr_q         <= rr_d;
            tag_vld_q    <= {tag_vld_q[LAT-1:0], gnt_any};
            tag_own_q[0] <= gnt_idx;
            for (int unsigned j = 1; j <= LAT; j++) tag_own_q[j] <= tag_own_q[j-1];
            if (gnt_any) in_q <= gnt_byte;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        push      = '0;
        pop       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid[i]        = (fifo_cnt_q[i] != '0);
            rsp_data[8*i +: 8]  = mem_q[i][rd_ptr_q[i]];
            push[i]             = tag_vld_q[LAT] && (tag_own_q[LAT] == IW'(i));
            pop[i]              = rsp_valid[i] && rsp_ready[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                rd_ptr_q[i]   <= '0;
                wr_ptr_q[i]   <= '0;
                fifo_cnt_q[i] <= '0;
                infl_cnt_q[i] <= '0;
                for (int unsigned j = 0; j < RSP_DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (push[i]) begin
                    mem_q[i][wr_ptr_q[i]] <= sbox_out;
                    wr_ptr_q[i]           <= ptr_inc(wr_ptr_q[i]);
                end
                if (pop[i]) rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                case ({push[i], pop[i]})
                    2'b10:   fifo_cnt_q[i] <= fifo_cnt_q[i] + CW'(1);
                    2'b01:   fifo_cnt_q[i] <= fifo_cnt_q[i] - CW'(1);
                    default: fifo_cnt_q[i] <= fifo_cnt_q[i];
                endcase
                case ({gnt[i], push[i]})
                    2'b10:   infl_cnt_q[i] <= infl_cnt_q[i] + CW'(1);
                    2'b01:   infl_cnt_q[i] <= infl_cnt_q[i] - CW'(1);
                    default: infl_cnt_q[i] <= infl_cnt_q[i];
                endcase
            end
        end
    end

    assign busy = (|tag_vld_q) || (|rsp_valid);

endmodule
